pcint_ctrl: RTL and testbench

- Pin-change interrupt unit covering all four PCINT groups, PCINT[27:0]; group 3 (PCINT[27:24]) is the Port E group.
- Owns the PCICR, PCIFR and PCMSK0..3 registers.
- Synchronises the pin inputs, detects masked changes, sets the per-group flags and drives interrupt requests to the interrupt controller with an acknowledge handshake.
- Also configures the ports by supplying the per-pin PCINT enables and the PCIEn bits that the port blocks use for digital-input-enable overrides.

---
 rtl/pcint_ctrl_if.sv | 26 ++
 rtl/pcint_ctrl.sv | 140 ++++++++++++++
 tb/tb_pcint_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/pcint_ctrl_if.sv
// Bus and interrupt handshake bundle for pcint_ctrl.
//   master : CPU / interrupt-controller side (drives strobes, addresses, write data, acks)
//   slave  : pcint_ctrl side (drives read data, out_en, irq)
interface pcint_ctrl_if;
    logic [5:0] IO_Addr;
    logic       iore;
    logic       iowe;
    logic [7:0] ramadr;
    logic       ramre;
    logic       ramwe;
    logic [7:0] dbus_in;
    logic [7:0] dbus_out;
    logic       out_en;
    logic [3:0] irq;
    logic [3:0] irq_ack;

    modport master (
        output IO_Addr, iore, iowe, ramadr, ramre, ramwe, dbus_in, irq_ack,
        input  dbus_out, out_en, irq
    );

    modport slave (
        input  IO_Addr, iore, iowe, ramadr, ramre, ramwe, dbus_in, irq_ack,
        output dbus_out, out_en, irq
    );
endinterface

// File: rtl/pcint_ctrl.sv
// Pin-change interrupt unit for PCINT[27:0] (four groups; group 3 = Port E).
// Owns PCICR, PCIFR and PCMSK0..3, synchronises the pins, raises per-group
// flags on masked changes and presents irq to the interrupt controller.
// Ports:
//   cp2, ireset  : clock (rising edge), async active-low reset
//   bus          : register access (I/O and data-memory space) + irq/irq_ack
//   pcint_pins   : raw pin levels
//   pcint_en     : per-pin enables to the port blocks
//   pcie         : PCICR[3:0] to the port blocks

// One group flag: set wins over clear when both land on the same edge.
module pcint_flag (
    input  logic       cp2,
    input  logic       ireset,
    input  logic [7:0] hit,
    input  logic       clr,
    output logic       flag
);
    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset)   flag <= 1'b0;
        else if (|hit) flag <= 1'b1;
        else if (clr)  flag <= 1'b0;
    end
endmodule

module pcint_ctrl #(
    parameter logic [5:0] PCIFR_IO_ADDR   = 6'h1B,
    parameter logic [7:0] PCICR_MEM_ADDR  = 8'h68,
    parameter logic [7:0] PCMSK0_MEM_ADDR = 8'h6B,
    parameter logic [7:0] PCMSK3_MEM_ADDR = 8'h73
) (
    input  logic         cp2,
    input  logic         ireset,
    pcint_ctrl_if.slave  bus,
    input  logic [27:0]  pcint_pins,
    output logic [27:0]  pcint_en,
    output logic [3:0]   pcie
);
    localparam int         NUM_GRP         = 4;
    localparam logic [7:0] PCMSK1_MEM_ADDR = PCMSK0_MEM_ADDR + 8'd1;
    localparam logic [7:0] PCMSK2_MEM_ADDR = PCMSK0_MEM_ADDR + 8'd2;

    logic [3:0]  pcicr;
    logic [7:0]  pcmsk0;
    logic [6:0]  pcmsk1;
    logic [7:0]  pcmsk2;
    logic [3:0]  pcmsk3;
    logic [3:0]  pcifr;

    logic [27:0] sync1, sync2, hist, change;
    logic [1:0]  warm;

    logic        io_sel_pcifr;
    logic        wr_pcifr;
    logic [3:0]  clr;
    logic [NUM_GRP-1:0][7:0] hit;

    // ---------------- register writes ----------------
    assign io_sel_pcifr = (bus.IO_Addr == PCIFR_IO_ADDR);
    assign wr_pcifr     = bus.iowe && io_sel_pcifr;

    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            pcicr  <= '0;
            pcmsk0 <= '0;
            pcmsk1 <= '0;
            pcmsk2 <= '0;
            pcmsk3 <= '0;
        end else if (bus.ramwe) begin
            if (bus.ramadr == PCICR_MEM_ADDR)  pcicr  <= bus.dbus_in[3:0];
            if (bus.ramadr == PCMSK0_MEM_ADDR) pcmsk0 <= bus.dbus_in;
            if (bus.ramadr == PCMSK1_MEM_ADDR) pcmsk1 <= bus.dbus_in[6:0];
            if (bus.ramadr == PCMSK2_MEM_ADDR) pcmsk2 <= bus.dbus_in;
            if (bus.ramadr == PCMSK3_MEM_ADDR) pcmsk3 <= bus.dbus_in[3:0];
        end
    end

    // ---------------- register reads ----------------
    always_comb begin
        bus.dbus_out = 8'h00;
        bus.out_en   = 1'b0;
        if (bus.iore && io_sel_pcifr) begin
            bus.out_en   = 1'b1;
            bus.dbus_out = {4'h0, pcifr};
        end else if (bus.ramre) begin
            bus.out_en = 1'b1;
            case (bus.ramadr)
                PCICR_MEM_ADDR:  bus.dbus_out = {4'h0, pcicr};
                PCMSK0_MEM_ADDR: bus.dbus_out = pcmsk0;
                PCMSK1_MEM_ADDR: bus.dbus_out = {1'b0, pcmsk1};
                PCMSK2_MEM_ADDR: bus.dbus_out = pcmsk2;
                PCMSK3_MEM_ADDR: bus.dbus_out = {4'h0, pcmsk3};
                default:         bus.out_en   = 1'b0;
            endcase
        end
    end

    // ---------------- pin path ----------------
    // While warming up, hist follows sync1 instead of sync2 so that when the
    // counter reaches zero hist already equals sync2; otherwise a pin held
    // high through reset would look like a 0->1 edge one cycle after warm-up.
    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            sync1 <= '0;
            sync2 <= '0;
            hist  <= '0;
            warm  <= 2'd2;
        end else begin
            sync1 <= pcint_pins;
            sync2 <= sync1;
            hist  <= (warm != 2'd0) ? sync1 : sync2;
            if (warm != 2'd0) warm <= warm - 2'd1;
        end
    end

    assign change = (warm != 2'd0) ? '0 : (sync2 ^ hist);

    // ---------------- flags / irq ----------------
    assign pcint_en = {pcmsk3, pcmsk2, 1'b0, pcmsk1, pcmsk0};
    assign pcie     = pcicr;

    assign hit[0] = change[7:0]   & pcint_en[7:0];
    assign hit[1] = change[15:8]  & pcint_en[15:8];
    assign hit[2] = change[23:16] & pcint_en[23:16];
    assign hit[3] = {4'h0, change[27:24] & pcint_en[27:24]};

    assign clr = (wr_pcifr ? bus.dbus_in[3:0] : 4'h0) | bus.irq_ack;

    for (genvar g = 0; g < NUM_GRP; g++) begin : g_grp
        pcint_flag u_flag (
            .cp2    (cp2),
            .ireset (ireset),
            .hit    (hit[g]),
            .clr    (clr[g]),
            .flag   (pcifr[g])
        );
    end

    assign bus.irq = pcifr & pcicr;
endmodule

// File: tb/tb_pcint_ctrl.sv
module tb_pcint_ctrl;
    logic        cp2 = 1'b0;
    logic        ireset = 1'b0;
    logic [27:0] pins;
    logic [27:0] pcint_en;
    logic [3:0]  pcie;

    int n_tests = 0;
    int n_fail  = 0;

    pcint_ctrl_if bus();

    pcint_ctrl dut (
        .cp2        (cp2),
        .ireset     (ireset),
        .bus        (bus.slave),
        .pcint_pins (pins),
        .pcint_en   (pcint_en),
        .pcie       (pcie)
    );

    always #5 cp2 = ~cp2;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // advance one edge; inputs change and outputs are sampled 1 ns after it
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge cp2);
            #1;
        end
    endtask

    task automatic mem_wr(input logic [7:0] a, input logic [7:0] d);
        bus.ramadr  = a;
        bus.dbus_in = d;
        bus.ramwe   = 1'b1;
        tick();
        bus.ramwe   = 1'b0;
    endtask

    task automatic io_wr(input logic [7:0] d);
        bus.IO_Addr = 6'h1B;
        bus.dbus_in = d;
        bus.iowe    = 1'b1;
        tick();
        bus.iowe    = 1'b0;
    endtask

    task automatic mem_rd(input logic [7:0] a, output logic [7:0] d, output logic oe);
        bus.ramadr = a;
        bus.ramre  = 1'b1;
        #1;
        d  = bus.dbus_out;
        oe = bus.out_en;
        bus.ramre  = 1'b0;
        #1;
    endtask

    task automatic pcifr_rd(output logic [7:0] d);
        bus.IO_Addr = 6'h1B;
        bus.iore    = 1'b1;
        #1;
        d = bus.dbus_out;
        bus.iore    = 1'b0;
        #1;
    endtask

    logic [7:0] d;
    logic       oe;

    initial begin
        bus.IO_Addr = '0; bus.iore = 0; bus.iowe = 0;
        bus.ramadr  = '0; bus.ramre = 0; bus.ramwe = 0;
        bus.dbus_in = '0; bus.irq_ack = '0;
        pins = 28'h0F00_0000;

        vecs[0] = '{8'h68, 8'hFF, 8'h0F};
        vecs[1] = '{8'h6B, 8'hA5, 8'hA5};
        vecs[2] = '{8'h6C, 8'hFF, 8'h7F};
        vecs[3] = '{8'h6D, 8'h3C, 8'h3C};
        vecs[4] = '{8'h73, 8'hFF, 8'h0F};
        vecs[5] = '{8'h73, 8'h04, 8'h04};

        // ---- 1: reset with Port E pins high, no false edge ----
        #2;
        chk("rst pcie", pcie, 4'h0);
        chk("rst pcint_en", pcint_en, 28'h0);
        tick(3);
        ireset = 1'b1;
        tick(10);
        pcifr_rd(d);
        chk("t1 pcifr", d, 8'h00);
        chk("t1 irq", bus.irq, 4'h0);

        // ---- register map table ----
        for (int i = 0; i < 6; i++) begin
            mem_wr(vecs[i].addr, vecs[i].wdata);
            mem_rd(vecs[i].addr, d, oe);
            chk($sformatf("reg[%0d] data", i), d, vecs[i].exp);
            chk($sformatf("reg[%0d] oe", i), oe, 1'b1);
        end
        chk("tbl pcint_en", pcint_en, {4'h4, 8'h3C, 1'b0, 7'h7F, 8'hA5});
        chk("tbl pcie", pcie, 4'hF);
        pcifr_rd(d);
        chk("tbl pcifr", d, 8'h00);
        mem_wr(8'h6B, 8'h00);
        mem_wr(8'h6C, 8'h00);
        mem_wr(8'h6D, 8'h00);

        // ---- 2: pin 26 toggle, latency and irq_ack ----
        mem_wr(8'h73, 8'h04);
        mem_wr(8'h68, 8'h08);
        pins[26] = 1'b0;
        tick();                 // edge k samples the toggle
        pcifr_rd(d);
        chk("t2 k", d, 8'h00);
        tick();
        pcifr_rd(d);
        chk("t2 k+1", d, 8'h00);
        tick();
        pcifr_rd(d);
        chk("t2 k+2", d, 8'h08);
        chk("t2 irq", bus.irq, 4'b1000);
        bus.irq_ack = 4'b1000;
        tick();
        bus.irq_ack = 4'b0000;
        pcifr_rd(d);
        chk("t2 ack pcifr", d, 8'h00);
        chk("t2 ack irq", bus.irq, 4'h0);

        // ---- 3: masked pin ignored, mask change ----
        pins[25] = 1'b0;
        tick(4);
        pcifr_rd(d);
        chk("t3 masked", d, 8'h00);
        chk("t3 en 4", pcint_en[27:24], 4'h4);
        mem_wr(8'h73, 8'h02);
        chk("t3 en 2", pcint_en[27:24], 4'h2);
        pins[25] = 1'b1;
        tick(3);
        pcifr_rd(d);
        chk("t3 flag", d, 8'h08);
        io_wr(8'h08);
        pcifr_rd(d);
        chk("t3 w1c", d, 8'h00);

        // ---- 4: flag without PCIE, then enable, then W1C ----
        mem_wr(8'h68, 8'h00);
        mem_wr(8'h6D, 8'h01);
        pins[16] = 1'b1;
        tick(3);
        pcifr_rd(d);
        chk("t4 flag", d, 8'h04);
        chk("t4 irq off", bus.irq, 4'h0);
        mem_wr(8'h68, 8'h04);
        chk("t4 irq on", bus.irq, 4'b0100);
        io_wr(8'h04);
        pcifr_rd(d);
        chk("t4 clr pcifr", d, 8'h00);
        chk("t4 clr irq", bus.irq, 4'h0);

        // ---- 5: W1C and new change on the same edge: set wins ----
        mem_wr(8'h6B, 8'h01);
        pins[0] = 1'b1;
        tick(3);
        pcifr_rd(d);
        chk("t5 first", d, 8'h01);
        pins[0] = 1'b0;
        tick(2);                // edges k, k+1
        bus.IO_Addr = 6'h1B;
        bus.dbus_in = 8'h01;
        bus.iowe    = 1'b1;
        tick();                 // edge k+2: set and clear together
        bus.iowe    = 1'b0;
        pcifr_rd(d);
        chk("t5 collide", d, 8'h01);
        io_wr(8'h01);
        pcifr_rd(d);
        chk("t5 w1c", d, 8'h00);

        // ---- 6: PCMSK1 read-back, out_en decode ----
        mem_wr(8'h6C, 8'hFF);
        mem_rd(8'h6C, d, oe);
        chk("t6 pcmsk1", d, 8'h7F);
        chk("t6 oe", oe, 1'b1);
        bus.ramadr = 8'h6C;
        #1;
        chk("t6 oe idle", bus.out_en, 1'b0);
        mem_rd(8'h70, d, oe);
        chk("t6 unmapped d", d, 8'h00);
        chk("t6 unmapped oe", oe, 1'b0);
        bus.IO_Addr = 6'h1C;
        bus.iore    = 1'b1;
        #1;
        chk("t6 io other oe", bus.out_en, 1'b0);
        bus.iore    = 1'b0;

        // ---- mid-operation reset ----
        pins[0] = 1'b1;
        tick(3);
        pcifr_rd(d);
        chk("rst2 pre", d, 8'h01);
        ireset = 1'b0;
        #1;
        pcifr_rd(d);
        chk("rst2 pcifr", d, 8'h00);
        chk("rst2 pcie", pcie, 4'h0);
        chk("rst2 en", pcint_en, 28'h0);
        tick(2);
        ireset = 1'b1;
        mem_wr(8'h73, 8'h0F);
        mem_wr(8'h6B, 8'hFF);
        tick(6);
        pcifr_rd(d);
        chk("rst2 warm", d, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
